pipeline_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage MIPS core.
- Drives the enable and synchronous-clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC register enable.
- Resolves load-use stalls, taken-branch flushes, multi-cycle mult/div occupancy, memory-bus wait and halt/resume.
- Keeps a stall-cycle performance counter.

---
 rtl/cpu_ctrl_pkg.sv | 12 +
 rtl/stall_perf_counter.sv | 29 ++
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU control blocks.
//   - FSM state encoding for pipeline_ctrl (RUN / MD_BUSY / HALTED)
//   - Default mult/div occupancy in EX stage cycles
package cpu_ctrl_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MD_BUSY = 2'd1;
  localparam logic [1:0] ST_HALTED  = 2'd2;

  localparam int MD_CYCLES_DEF = 32;

endpackage

// File: rtl/stall_perf_counter.sv
// Free-running wrapping event counter used for stall-cycle accounting.
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, clears the count
//   inc   in   add one on this clock edge
//   count out  current count, wraps modulo 2^PERF_BITS
module stall_perf_counter #(
  parameter int PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [PERF_BITS-1:0] count
);

  logic [PERF_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage MIPS pipeline.
// Produces PC / pipeline-register enables and bubble clears from the hazard
// inputs, tracks mult/div EX occupancy and halt/resume, and counts stalls.
//   clk, rst                  clock, async active-high reset
//   load_use, branch_taken    hazard inputs from ID/EX
//   md_start                  mult/div issuing in EX
//   mem_wait                  bus not ready, freeze everything
//   halt, resume              halt request / leave halted state
//   pc_en .. memwb_en         register enables (combinational)
//   ifid_clr .. exmem_clr     synchronous clears, dominate enables
//   md_busy, halted           state decode
//   stall_cycles              cycles with PC frozen outside HALTED
module pipeline_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int CNT_BITS  = 6,
  parameter int PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_use,
  input  logic                 branch_taken,
  input  logic                 md_start,
  input  logic                 mem_wait,
  input  logic                 halt,
  input  logic                 resume,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_clr,
  output logic                 idex_clr,
  output logic                 exmem_clr,
  output logic                 md_busy,
  output logic                 halted,
  output logic [PERF_BITS-1:0] stall_cycles
);

  localparam logic [CNT_BITS-1:0] MD_LOAD = CNT_BITS'(MD_CYCLES - 1);
  localparam bit                  MD_MULTI = (MD_CYCLES > 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] md_cnt_q, md_cnt_d;
  logic                stall_inc;

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
        end else if (halt) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
          state_d = ST_HALTED;
        end else if (md_start && MD_MULTI) begin
          // Hold the md op in EX; MEM gets a bubble, WB drains normally.
          {pc_en, ifid_en, idex_en} = 3'b0;
          exmem_clr = 1'b1;
          md_cnt_d  = MD_LOAD;
          state_d   = ST_MD_BUSY;
        end else if (branch_taken) begin
          // Branch beats load-use: the stalled instruction is squashed anyway.
          ifid_clr = 1'b1;
          idex_clr = 1'b1;
        end else if (load_use) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_clr = 1'b1;
        end
      end
      ST_MD_BUSY: begin
        if (mem_wait) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
        end else begin
          {pc_en, ifid_en, idex_en} = 3'b0;
          exmem_clr = 1'b1;
          // <=1 also recovers from an impossible zero count.
          if (md_cnt_q <= CNT_BITS'(1)) begin
            md_cnt_d = '0;
            state_d  = ST_RUN;
          end else begin
            md_cnt_d = md_cnt_q - 1'b1;
          end
        end
      end
      ST_HALTED: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy   = (state_q == ST_MD_BUSY);
  assign halted    = (state_q == ST_HALTED);
  assign stall_inc = ~pc_en & ~halted;

  stall_perf_counter #(.PERF_BITS(PERF_BITS)) u_perf (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int PB = 4;

  logic clk, rst;
  logic load_use, branch_taken, md_start, mem_wait, halt, resume;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_clr, idex_clr, exmem_clr, md_busy, halted;
  logic [PB-1:0] stall_cycles;
  logic [7:0] outs;

  int ncmp = 0;
  int nfail = 0;

  // {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem clears}
  localparam logic [7:0] O_DEF  = 8'b11111_000;
  localparam logic [7:0] O_ZERO = 8'b00000_000;
  localparam logic [7:0] O_MD   = 8'b00011_001;
  localparam logic [7:0] O_LU   = 8'b00111_010;
  localparam logic [7:0] O_BR   = 8'b11111_110;

  pipeline_ctrl #(.MD_CYCLES(4), .CNT_BITS(6), .PERF_BITS(PB)) dut (
    .clk(clk), .rst(rst),
    .load_use(load_use), .branch_taken(branch_taken), .md_start(md_start),
    .mem_wait(mem_wait), .halt(halt), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_clr(ifid_clr), .idex_clr(idex_clr), .exmem_clr(exmem_clr),
    .md_busy(md_busy), .halted(halted), .stall_cycles(stall_cycles)
  );

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on negedge; checks land 1 time unit later, far from posedge.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    {load_use, branch_taken, md_start, mem_wait, halt, resume} = '0;
    rst = 1'b1;
    nxt(); #1;
    chk("rst_outs", 32'(outs), 32'(O_DEF));
    chk("rst_stall", 32'(stall_cycles), 0);
    chk("rst_busy", 32'(md_busy), 0);
    chk("rst_halted", 32'(halted), 0);
    nxt(); rst = 1'b0;

    // idle
    for (int i = 0; i < 10; i++) begin
      nxt(); #1;
      chk("idle_outs", 32'(outs), 32'(O_DEF));
      chk("idle_stall", 32'(stall_cycles), 0);
    end

    // async reset in MD_BUSY
    nxt(); md_start = 1'b1; #1;
    chk("mdr_issue", 32'(outs), 32'(O_MD));
    nxt(); md_start = 1'b0; #1;
    chk("mdr_busy", 32'(md_busy), 1);
    chk("mdr_stall", 32'(stall_cycles), 1);
    #1 rst = 1'b1; #1;
    chk("arst_busy", 32'(md_busy), 0);
    chk("arst_stall", 32'(stall_cycles), 0);
    chk("arst_outs", 32'(outs), 32'(O_DEF));
    nxt(); rst = 1'b0; #1;
    chk("arst_hold", 32'(md_busy), 0);
    chk("arst_hold_stall", 32'(stall_cycles), 0);

    // load-use
    nxt(); load_use = 1'b1; #1;
    chk("lu_outs", 32'(outs), 32'(O_LU));
    nxt(); load_use = 1'b0; #1;
    chk("lu_after", 32'(outs), 32'(O_DEF));
    chk("lu_stall", 32'(stall_cycles), 1);

    // branch + load-use
    nxt(); branch_taken = 1'b1; load_use = 1'b1; #1;
    chk("br_outs", 32'(outs), 32'(O_BR));
    nxt(); branch_taken = 1'b0; load_use = 1'b0; #1;
    chk("br_after", 32'(outs), 32'(O_DEF));
    chk("br_stall", 32'(stall_cycles), 1);

    // mult/div, 4 cycles
    nxt(); md_start = 1'b1; #1;
    chk("md_issue", 32'(outs), 32'(O_MD));
    chk("md_issue_busy", 32'(md_busy), 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); md_start = 1'b0; #1;
      chk("md_outs", 32'(outs), 32'(O_MD));
      chk("md_busy", 32'(md_busy), 1);
    end
    nxt(); #1;
    chk("md_done", 32'(outs), 32'(O_DEF));
    chk("md_done_busy", 32'(md_busy), 0);
    chk("md_stall", 32'(stall_cycles), 5);

    // mult/div with mem_wait in the middle
    nxt(); md_start = 1'b1; #1;
    chk("mw_issue", 32'(outs), 32'(O_MD));
    nxt(); md_start = 1'b0; #1;
    chk("mw_b1", 32'(outs), 32'(O_MD));
    for (int i = 0; i < 2; i++) begin
      nxt(); mem_wait = 1'b1; #1;
      chk("mw_wait", 32'(outs), 32'(O_ZERO));
      chk("mw_wait_busy", 32'(md_busy), 1);
    end
    nxt(); mem_wait = 1'b0; #1;
    chk("mw_b2", 32'(outs), 32'(O_MD));
    nxt(); #1;
    chk("mw_b3", 32'(outs), 32'(O_MD));
    chk("mw_b3_busy", 32'(md_busy), 1);
    nxt(); #1;
    chk("mw_done", 32'(outs), 32'(O_DEF));
    chk("mw_done_busy", 32'(md_busy), 0);
    chk("mw_stall", 32'(stall_cycles), 11);

    // halt / resume
    nxt(); halt = 1'b1; #1;
    chk("h_req", 32'(outs), 32'(O_ZERO));
    chk("h_req_halted", 32'(halted), 0);
    for (int i = 0; i < 5; i++) begin
      nxt(); halt = 1'b0; resume = (i == 4); #1;
      chk("h_outs", 32'(outs), 32'(O_ZERO));
      chk("h_halted", 32'(halted), 1);
      chk("h_stall", 32'(stall_cycles), 12);
    end
    nxt(); resume = 1'b0; #1;
    chk("h_resumed", 32'(outs), 32'(O_DEF));
    chk("h_resumed_halted", 32'(halted), 0);
    chk("h_resumed_stall", 32'(stall_cycles), 12);

    // counter wrap: 12 -> 15 -> 0
    for (int i = 0; i < 3; i++) begin
      nxt(); load_use = 1'b1;
    end
    nxt(); load_use = 1'b0; #1;
    chk("wrap_pre", 32'(stall_cycles), 15);
    nxt(); load_use = 1'b1;
    nxt(); load_use = 1'b0; #1;
    chk("wrap_zero", 32'(stall_cycles), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
